serial_transceiver_fifo: RTL and testbench

//  Parametrised successor to the single-word serial transmitter. Buffers up to DEPTH sampled parallel

---
 rtl/serial_tx_pkg.sv | 14 +
 rtl/serial_tx_fifo_buf.sv | 61 ++++++
 rtl/serial_transceiver_fifo.sv | 115 +++++++++++
 tb/tb_serial_transceiver_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the buffered serial transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } tx_state_e;

  function automatic int unsigned nchunk(input int unsigned din_w, input int unsigned dout_w);
    return (din_w + dout_w - 1) / dout_w;
  endfunction

endpackage

// File: rtl/serial_tx_fifo_buf.sv
// Synchronous word FIFO with registered full/empty flags derived from the next count.
module serial_tx_fifo_buf #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             din,
  input  logic                     push,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          wr;
  logic          rd;
  logic [AW:0]   count_nx;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    rd       = pop && !empty;
    wr       = push && (!full || rd);
    count_nx = count;
    case ({wr, rd})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count_nx;
      full  <= (count_nx == FULLC);
      empty <= (count_nx == '0);
    end
  end

endmodule

// File: rtl/serial_transceiver_fifo.sv
// FIFO-buffered serialiser: words leave as DOUT_W-bit chunks, LSB chunk first, one per txTick.
// Optional even-parity output dpar when SERIAL_TX_PARITY_EN is defined.
module serial_transceiver_fifo
  import serial_tx_pkg::*;
#(
  parameter int unsigned DIN_W  = 32,
  parameter int unsigned DOUT_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CONT   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIN_W-1:0]  din,
  input  logic              sample,
  input  logic              startTx,
  input  logic              txTick,
  output logic [DOUT_W-1:0] dout,
  output logic              txBusy,
  output logic              txDone,
  output logic              full,
  output logic              empty,
  output logic              ovf
`ifdef SERIAL_TX_PARITY_EN
  ,
  output logic              dpar
`endif
);

  localparam int unsigned NCHUNK = nchunk(DIN_W, DOUT_W);
  localparam int unsigned SHW    = NCHUNK * DOUT_W;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  tx_state_e                state;
  logic [SHW-1:0]           shreg;
  logic [IDXW-1:0]          idx;
  logic [DIN_W-1:0]         head;
  logic [$clog2(DEPTH):0]   fifo_cnt;
  logic                     has_word;
  logic                     load;
  logic [DOUT_W-1:0]        chunk;

  serial_tx_fifo_buf #(
    .W     (DIN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .push  (sample),
    .pop   (load),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign has_word = (fifo_cnt != '0);
  assign chunk    = shreg[32'(idx) * DOUT_W +: DOUT_W];

  always_comb begin
    load = 1'b0;
    if (has_word) begin
      if (state == IDLE && startTx)  load = 1'b1;
      if (state == DONE && CONT != 0) load = 1'b1;
    end
  end

  // IDLE and DONE share the load path; load already encodes which trigger applies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shreg  <= '0;
      idx    <= '0;
      dout   <= '0;
      txBusy <= 1'b0;
      txDone <= 1'b0;
      ovf    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      dpar   <= 1'b0;
`endif
    end else begin
      txDone <= 1'b0;
      if (sample && full && !load) ovf <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            shreg  <= SHW'(head);
            idx    <= '0;
            txBusy <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          if (txTick) begin
            dout <= chunk;
`ifdef SERIAL_TX_PARITY_EN
            dpar <= ^chunk;
`endif
            idx  <= idx + 1'b1;
            if (idx == LAST) begin
              state  <= DONE;
              txBusy <= 1'b0;
              txDone <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transceiver_fifo.sv
// Bench for serial_transceiver_fifo: a queue-based model checked every cycle plus directed literal checks.
module tb_serial_transceiver_fifo;

  localparam int DEPTH = 4;
  localparam int NCH   = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din = '0;
  logic        sample = 1'b0;
  logic        startTx = 1'b0;
  logic        txTick = 1'b0;

  logic [4:0]  dout0, dout1;
  logic        busy0, busy1, done0, done1, full0, full1, empty0, empty1, ovf0, ovf1;
  logic        dpar0, dpar1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_transceiver_fifo #(.DIN_W(32), .DOUT_W(5), .DEPTH(DEPTH), .CONT(0)) u_dut0 (
    .clk(clk), .reset(reset), .din(din), .sample(sample), .startTx(startTx), .txTick(txTick),
    .dout(dout0), .txBusy(busy0), .txDone(done0), .full(full0), .empty(empty0), .ovf(ovf0)
`ifdef SERIAL_TX_PARITY_EN
    , .dpar(dpar0)
`endif
  );

  serial_transceiver_fifo #(.DIN_W(32), .DOUT_W(5), .DEPTH(DEPTH), .CONT(1)) u_dut1 (
    .clk(clk), .reset(reset), .din(din), .sample(sample), .startTx(startTx), .txTick(txTick),
    .dout(dout1), .txBusy(busy1), .txDone(done1), .full(full1), .empty(empty1), .ovf(ovf1)
`ifdef SERIAL_TX_PARITY_EN
    , .dpar(dpar1)
`endif
  );

`ifndef SERIAL_TX_PARITY_EN
  assign dpar0 = 1'b0;
  assign dpar1 = 1'b0;
`endif

  // Model: a word list per instance; a started word becomes a chunk stream computed by shifting.
  logic [31:0] mw [2][DEPTH];
  int          mcnt [2];
  logic [31:0] mcur [2];
  int          mk [2];
  logic [4:0]  e_dout [2];
  bit          e_busy [2], e_done [2], e_ovf [2], e_dpar [2];

  task automatic model_step(input int m);
    bit take;
    bit nd;
    logic [31:0] c;
    take = (mcnt[m] > 0) && ((!e_busy[m] && !e_done[m] && startTx) || (e_done[m] && m == 1));
    nd = 1'b0;
    if (take) begin
      mcur[m] = mw[m][0];
      for (int i = 0; i < DEPTH - 1; i++) mw[m][i] = mw[m][i+1];
      mcnt[m] = mcnt[m] - 1;
      mk[m] = 0;
      e_busy[m] = 1'b1;
    end else if (e_busy[m] && txTick) begin
      c = (mcur[m] >> (mk[m] * 5)) & 32'h1f;
      e_dout[m] = c[4:0];
      e_dpar[m] = ^c;
      mk[m] = mk[m] + 1;
      if (mk[m] == NCH) begin
        e_busy[m] = 1'b0;
        nd = 1'b1;
      end
    end
    e_done[m] = nd;
    if (sample) begin
      if (mcnt[m] < DEPTH) begin
        mw[m][mcnt[m]] = din;
        mcnt[m] = mcnt[m] + 1;
      end else begin
        e_ovf[m] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        mcnt[m] = 0; mk[m] = 0; mcur[m] = '0; e_dout[m] = '0;
        e_busy[m] = 1'b0; e_done[m] = 1'b0; e_ovf[m] = 1'b0; e_dpar[m] = 1'b0;
      end else begin
        model_step(m);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [10:0] act;
        logic [10:0] exp;
        bit ep;
`ifdef SERIAL_TX_PARITY_EN
        ep = e_dpar[m];
`else
        ep = 1'b0;
`endif
        act = (m == 0) ? {dout0, busy0, done0, full0, empty0, ovf0, dpar0}
                       : {dout1, busy1, done1, full1, empty1, ovf1, dpar1};
        exp = {e_dout[m], e_busy[m], e_done[m], mcnt[m] == DEPTH, mcnt[m] == 0, e_ovf[m], ep};
        tests++;
        if (act !== exp) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t got {dout,busy,done,full,empty,ovf,dpar}=%b exp %b",
                   m, $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample = 1'b0; startTx = 1'b0; txTick = 1'b0; din = '0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    din = w; sample = 1'b1;
    cyc();
    sample = 1'b0;
  endtask

  logic [4:0] t1exp [NCH] = '{5'h11, 5'h07, 5'h04, 5'h1E, 5'h10, 5'h18, 5'h03};

  initial begin
    int bcnt;
    int dcnt;
    int dpos [3];

    // 1: single word, tick every clock
    do_reset();
    chk_en = 1'b1;
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_flags", {busy0, done0, full0, empty0, ovf0}, 32'b00010);
    push_word(32'hF10F10F1);
    txTick = 1'b1; startTx = 1'b1;
    cyc();
    startTx = 1'b0;
    bcnt = busy0; dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i < NCH) chk($sformatf("t1_chunk%0d", i), 32'(dout0), 32'(t1exp[i]));
      bcnt += busy0;
      dcnt += done0;
    end
    chk("t1_busy_clks", bcnt, 7);
    chk("t1_done_pulses", dcnt, 1);
    chk("t1_dout_hold", 32'(dout0), 32'h03);

    // 2: overflow and FIFO order
    do_reset();
    txTick = 1'b1;
    for (int w = 1; w <= 4; w++) push_word(32'(w));
    chk("t2_full", {full0, ovf0}, 32'b10);
    push_word(32'h5);
    chk("t2_ovf", {full0, ovf0}, 32'b11);
    for (int w = 1; w <= 4; w++) begin
      startTx = 1'b1;
      cyc();
      startTx = 1'b0;
      cyc();
      chk($sformatf("t2_order%0d", w), 32'(dout0), 32'(w));
      repeat (7) cyc();
    end
    chk("t2_empty", 32'(empty0), 1);

    // 3: continuous drain on the CONT=1 instance
    do_reset();
    txTick = 1'b1;
    push_word(32'h89ABCDEF);
    push_word(32'h12345678);
    push_word(32'hFFFFFFFF);
    startTx = 1'b1;
    cyc();
    startTx = 1'b0;
    bcnt = busy1; dcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 1) chk("t3_first_chunk", 32'(dout1), 32'h0F);
      if (i == 23) chk("t3_last_chunk", 32'(dout1), 32'h03);
      bcnt += busy1;
      if (done1) begin
        if (dcnt < 3) dpos[dcnt] = i;
        dcnt++;
      end
    end
    chk("t3_chunks", bcnt, 21);
    chk("t3_done_pulses", dcnt, 3);
    chk("t3_done_pos", {8'(dpos[0]), 8'(dpos[1]), 8'(dpos[2])}, {8'd7, 8'd15, 8'd23});
    chk("t3_empty", 32'(empty1), 1);

    // 4: tick every third clock
    do_reset();
    push_word(32'hF10F10F1);
    startTx = 1'b1;
    cyc();
    startTx = 1'b0;
    for (int i = 0; i < 23; i++) begin
      txTick = (i % 3 == 2);
      cyc();
      if (i >= 2) chk($sformatf("t4_hold%0d", i), 32'(dout0), 32'(t1exp[(i-2)/3]));
      if (i == 20) chk("t4_done", 32'(done0), 1);
    end
    txTick = 1'b0;

    // 5: reset mid-transfer
    do_reset();
    push_word(32'hF10F10F1);
    push_word(32'h0000ABCD);
    txTick = 1'b1; startTx = 1'b1;
    cyc();
    startTx = 1'b0;
    repeat (3) cyc();
    chk("t5_pre_chunk2", 32'(dout0), 32'h04);
    reset = 1'b0;
    #1;
    chk("t5_async_dout", 32'(dout0), 0);
    chk("t5_async_flags", {busy0, done0, full0, empty0, ovf0}, 32'b00010);
    cyc();
    reset = 1'b1;
    cyc();
    startTx = 1'b1;
    cyc();
    startTx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t5_quiet%0d", i), {busy0, done0, dout0}, 0);
    end

    // 6: push and load pop in the same cycle on a full FIFO
    do_reset();
    txTick = 1'b1;
    for (int w = 0; w < 4; w++) push_word(32'h13579BDF + 32'(w));
    chk("t6_full_before", 32'(full0), 1);
    din = 32'hA5A5A5A5; sample = 1'b1; startTx = 1'b1;
    cyc();
    sample = 1'b0; startTx = 1'b0;
    chk("t6_full_after", {full0, ovf0}, 32'b10);
    for (int i = 0; i < 8; i++) begin
      cyc();
`ifdef SERIAL_TX_PARITY_EN
      chk($sformatf("t6_dpar%0d", i), 32'(dpar0), 32'(^dout0));
`endif
    end
    chk("t6_no_ovf", {ovf0, ovf1}, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule
